// File: rtl/mips_cpu_load_store_unit_if.sv
// Purpose : bundles the LSU request/response signals and its Avalon-MM master bus.
// Ports   : start/opcode/eff_addr/rt_content in; busy/done/load_data/addr_error out;
//           avm_* word-wide Avalon-MM master (address, read, write, writedata, byteenable, waitrequest, readdata).
interface mips_cpu_load_store_unit_if;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] eff_addr;
    logic [31:0] rt_content;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        addr_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    // LSU side: consumes requests and read data, drives status and the bus
    modport master (
        input  start, opcode, eff_addr, rt_content, avm_waitrequest, avm_readdata,
        output busy, done, load_data, addr_error,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    // Environment side: core control plus the memory slave
    modport slave (
        output start, opcode, eff_addr, rt_content, avm_waitrequest, avm_readdata,
        input  busy, done, load_data, addr_error,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/mips_cpu_load_store_unit.sv
// Purpose : MIPS memory stage; one Avalon-MM word access per load/store, extracts/extends load data.
// Latency : done 2 cycles after start with zero wait states (+1 per wait state); 1 cycle for a misaligned abort.
// Backpres: holds the request while avm_waitrequest=1; busy stalls the core whenever not IDLE.
// Ports   : clk, reset (sync, active-high), bus (mips_cpu_load_store_unit_if.master).
module mips_cpu_load_store_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_cpu_load_store_unit_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26,
                           OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SW  = 6'h2B;

    state_t      r_state;
    logic [5:0]  r_op;
    logic [1:0]  r_k;
    logic [31:0] r_rt;
    logic        r_busy, r_done, r_addr_error, r_read, r_write;
    logic [31:0] r_load_data, r_address, r_writedata;
    logic [3:0]  r_be;

    logic        w_valid_op, w_is_load, w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shl, w_shr;
    logic [31:0] w_extract;

    // Request decode straight off the inputs; only used in IDLE when start is sampled
    always_comb begin
        w_valid_op   = 1'b1;
        w_is_load    = 1'b1;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = bus.rt_content;
        case (bus.opcode)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: begin
            end
            OP_LH, OP_LHU: w_misaligned = bus.eff_addr[0];
            OP_LW:         w_misaligned = |bus.eff_addr[1:0];
            OP_SB: begin
                w_is_load = 1'b0;
                w_be      = 4'b0001 << bus.eff_addr[1:0];
                w_wdata   = {4{bus.rt_content[7:0]}};
            end
            OP_SH: begin
                w_is_load    = 1'b0;
                w_misaligned = bus.eff_addr[0];
                w_be         = bus.eff_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{bus.rt_content[15:0]}};
            end
            OP_SW: begin
                w_is_load    = 1'b0;
                w_misaligned = |bus.eff_addr[1:0];
            end
            default: w_valid_op = 1'b0;
        endcase
    end

    // Load extraction from the raw read word using the latched byte offset
    assign w_byte = bus.avm_readdata[{r_k, 3'b000} +: 8];
    assign w_half = r_k[1] ? bus.avm_readdata[31:16] : bus.avm_readdata[15:0];
    assign w_shl  = {~r_k, 3'b000};   // 8*(3-k)
    assign w_shr  = {r_k, 3'b000};    // 8*k

    always_comb begin
        w_extract = bus.avm_readdata;
        case (r_op)
            OP_LB:  w_extract = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_extract = {24'd0, w_byte};
            OP_LH:  w_extract = {{16{w_half[15]}}, w_half};
            OP_LHU: w_extract = {16'd0, w_half};
            // Unaligned-word pair: merge the addressed bytes into rt, keeping rt's other lanes
            OP_LWL: w_extract = (bus.avm_readdata << w_shl) | (r_rt & ~(32'hFFFF_FFFF << w_shl));
            OP_LWR: w_extract = (bus.avm_readdata >> w_shr) | (r_rt & ~(32'hFFFF_FFFF >> w_shr));
            default: w_extract = bus.avm_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 6'd0;
            r_k          <= 2'd0;
            r_rt         <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr_error <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_load_data  <= 32'd0;
            r_address    <= 32'd0;
            r_writedata  <= 32'd0;
            r_be         <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done       <= 1'b0;
                    r_addr_error <= 1'b0;
                    if (bus.start && w_valid_op) begin
                        r_op   <= bus.opcode;
                        r_k    <= bus.eff_addr[1:0];
                        r_rt   <= bus.rt_content;
                        r_busy <= 1'b1;
                        if (ALIGN_CHECK && w_misaligned) begin
                            // Abort without touching the bus
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_addr_error <= 1'b1;
                            r_load_data  <= 32'd0;
                        end else begin
                            r_state     <= S_REQ;
                            r_read      <= w_is_load;
                            r_write     <= ~w_is_load;
                            r_address   <= {bus.eff_addr[31:2], 2'b00};
                            r_be        <= w_be;
                            r_writedata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (r_read) begin
                            r_load_data <= w_extract;
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_done       <= 1'b0;
                    r_addr_error <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.addr_error     = r_addr_error;
    assign bus.load_data      = r_load_data;
    assign bus.avm_address    = r_address;
    assign bus.avm_read       = r_read;
    assign bus.avm_write      = r_write;
    assign bus.avm_writedata  = r_writedata;
    assign bus.avm_byteenable = r_be;
endmodule
